// File: rtl/overlay_pkg.sv
// Shared types and helpers for the text overlay compositor.
// Character cell geometry, channel rect type, hit test and dim function.
package overlay_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int RGB_W  = 12;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  cols;
        logic [7:0]  rows;
    } rect_t;

    function automatic logic in_rect(rect_t r, logic [11:0] h, logic [11:0] v);
        logic [11:0] xe;
        logic [11:0] ye;
        xe = r.x + 12'(r.cols) * 12'(CHAR_W);
        ye = r.y + 12'(r.rows) * 12'(CHAR_H);
        return (h >= r.x) && (h < xe) && (v >= r.y) && (v < ye);
    endfunction

    function automatic logic [RGB_W-1:0] dim_rgb(logic [RGB_W-1:0] c, int unsigned sh);
        return {c[11:8] >> sh, c[7:4] >> sh, c[3:0] >> sh};
    endfunction

endpackage

// File: rtl/text_overlay_arbiter_if.sv
// VGA timing + pixel bundle passed between pipeline blocks.
interface itf_vga;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [overlay_pkg::RGB_W-1:0] rgb;

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/delay.sv
// Generic fixed-length register pipeline with asynchronous clear.
module delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [CLK_DEL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/overlay_blink_timer.sv
// Vsync edge detector, frame counter and blink phase for the overlay.
module overlay_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic frame_start,
    output logic blink_phase
);

    logic       vsync_q;
    logic [7:0] frame_cnt;

    assign frame_start = vsync && !vsync_q;

    // vsync_q clears to 1 so a vsync already high at release is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            vsync_q <= vsync;
            if (frame_start) begin
                if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/text_overlay_arbiter.sv
// Priority text overlay compositor sharing one font_rom port across N_CH channels.
// Optional background dimming under TEXT_OVERLAY_BG_DIM_EN.
module text_overlay_arbiter
    import overlay_pkg::*;
#(
    parameter int N_CH = 8,
    parameter logic [N_CH-1:0][11:0] CH_X    = '0,
    parameter logic [N_CH-1:0][11:0] CH_Y    = '0,
    parameter logic [N_CH-1:0][7:0]  CH_COLS = {N_CH{8'd1}},
    parameter logic [N_CH-1:0][7:0]  CH_ROWS = {N_CH{8'd1}},
    parameter int BLINK_FRAMES = 30,
    parameter int DIM_SHIFT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             ch_en,
    input  logic [N_CH-1:0]             ch_blink,
    input  logic                        dim,
    input  logic [N_CH-1:0][RGB_W-1:0]  ch_rgb,
    input  logic [N_CH-1:0][6:0]        ch_char_code,
    input  logic [N_CH-1:0][3:0]        ch_char_line,
    output logic [10:0]                 addr,
    output logic                        hit_valid,
    output logic [$clog2(N_CH)-1:0]     hit_ch,
    itf_vga.in                          in,
    itf_vga.out                         out
);

    localparam int CW = $clog2(N_CH);
    localparam int TW = 2 * 11 + 4 + RGB_W;

    logic [TW-1:0]    d_bus;
    logic [10:0]      d_hcount, d_vcount;
    logic             d_hsync, d_vsync, d_hblnk, d_vblnk;
    logic [RGB_W-1:0] d_rgb;

    delay #(.WIDTH(TW), .CLK_DEL(2)) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({in.hcount, in.vcount, in.hsync, in.vsync,
                in.hblnk, in.vblnk, in.rgb}),
        .dout (d_bus)
    );

    assign {d_hcount, d_vcount, d_hsync, d_vsync,
            d_hblnk, d_vblnk, d_rgb} = d_bus;

    logic frame_start, blink_phase;

    overlay_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk         (clk),
        .rst         (rst),
        .vsync       (in.vsync),
        .frame_start (frame_start),
        .blink_phase (blink_phase)
    );

    logic [N_CH-1:0] en_q, blink_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= '0;
            blink_q <= '0;
        end else if (frame_start) begin
            en_q    <= ch_en;
            blink_q <= ch_blink;
        end
    end

    logic [N_CH-1:0] hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam rect_t R = '{x: CH_X[i], y: CH_Y[i],
                                cols: CH_COLS[i], rows: CH_ROWS[i]};
        assign hit[i] = en_q[i] && (!blink_q[i] || blink_phase)
                        && in_rect(R, {1'b0, d_hcount}, {1'b0, d_vcount});
    end

    logic          granted;
    logic [CW-1:0] g;

    // Scan low priority first so the lowest hit index is left standing
    always_comb begin
        granted = 1'b0;
        g       = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                granted = 1'b1;
                g       = i[CW-1:0];
            end
        end
    end

    assign addr = granted ? {ch_char_code[g], ch_char_line[g]} : 11'd0;

    logic [RGB_W-1:0] rgb_nxt;

`ifdef TEXT_OVERLAY_BG_DIM_EN
    logic [RGB_W-1:0] bg_rgb;
    assign bg_rgb = dim ? dim_rgb(d_rgb, DIM_SHIFT) : d_rgb;
`else
    logic [RGB_W-1:0] bg_rgb;
    logic             unused_dim;
    assign bg_rgb     = d_rgb;
    assign unused_dim = dim;
`endif

    always_comb begin
        rgb_nxt = bg_rgb;
        if (d_hblnk || d_vblnk) rgb_nxt = '0;
        else if (granted)       rgb_nxt = ch_rgb[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
            hit_valid  <= 1'b0;
            hit_ch     <= '0;
        end else begin
            out.hcount <= d_hcount;
            out.vcount <= d_vcount;
            out.hsync  <= d_hsync;
            out.vsync  <= d_vsync;
            out.hblnk  <= d_hblnk;
            out.vblnk  <= d_vblnk;
            out.rgb    <= rgb_nxt;
            hit_valid  <= granted;
            hit_ch     <= g;
        end
    end

endmodule
